// File: rtl/l0_loader.sv
// l0_loader: streams num_vec consecutive activation words from the activation
// SRAM into the L0 row-FIFO bank. Reads are issued back-to-back; L0 backpressure
// is absorbed by a depth-1 skid register holding a word that returned while L0
// was full. done pulses for one cycle after the last word has been written.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   start                   begin transfer (sampled in IDLE only)
//   base_addr, num_vec      first SRAM address / word count (sampled with start)
//   busy, done              transfer in progress / 1-cycle completion pulse
//   sram_cen, sram_wen      SRAM chip enable / write enable (active-low)
//   sram_addr, sram_q       SRAM read address / read data (1-cycle latency)
//   l0_full                 per-FIFO full flags from L0
//   l0_wr, l0_in            L0 write strobe / write data
module l0_loader #(
  parameter int unsigned row    = 8,
  parameter int unsigned bw     = 4,
  parameter int unsigned ADDR_W = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       num_vec,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_cen,
  output logic                  sram_wen,
  output logic [ADDR_W-1:0]     sram_addr,
  input  logic [row*bw-1:0]     sram_q,
  input  logic [row-1:0]        l0_full,
  output logic                  l0_wr,
  output logic [row*bw-1:0]     l0_in
);

  localparam int unsigned WORD_W = row * bw;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state,       state_n;
  logic [ADDR_W-1:0] base_q,      base_n;
  logic [CNT_W-1:0]  num_q,       num_n;
  logic [CNT_W-1:0]  issued,      issued_n;
  logic [CNT_W-1:0]  written,     written_n;
  logic              skid_valid,  skid_valid_n;
  logic [WORD_W-1:0] skid_data,   skid_data_n;
  logic              inflight,    inflight_n;

  logic              full_any;
  logic              issue;
  logic              wr;
  logic [WORD_W-1:0] wr_data;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      issued     <= '0;
      written    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      inflight   <= 1'b0;
    end else begin
      state      <= state_n;
      base_q     <= base_n;
      num_q      <= num_n;
      issued     <= issued_n;
      written    <= written_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      inflight   <= inflight_n;
    end
  end

  // Next-state, issue and return logic
  always_comb begin
    state_n      = state;
    base_n       = base_q;
    num_n        = num_q;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    wr           = 1'b0;
    wr_data      = '0;
    full_any     = |l0_full;

    // A read may only go out when its return is guaranteed a landing spot:
    // either L0 accepts it next cycle or the (empty) skid catches it.
    issue = (state == S_RUN) && (issued < num_q) && !full_any && !skid_valid;

    if (skid_valid) begin
      if (!full_any) begin
        wr           = 1'b1;
        wr_data      = skid_data;
        skid_valid_n = 1'b0;
      end
    end else if (inflight) begin
      if (!full_any) begin
        wr      = 1'b1;
        wr_data = sram_q;
      end else begin
        skid_valid_n = 1'b1;
        skid_data_n  = sram_q;
      end
    end

    inflight_n = issue;
    issued_n   = issued + CNT_W'(issue);
    written_n  = written + CNT_W'(wr);

    case (state)
      S_IDLE: begin
        if (start) begin
          base_n    = base_addr;
          num_n     = num_vec;
          issued_n  = '0;
          written_n = '0;
          state_n   = (num_vec == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (written_n == num_q) begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs; reset blocks any read or write in the cycle it is asserted
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign sram_wen  = 1'b1;
  assign sram_cen  = !(issue && !reset);
  assign sram_addr = base_q + issued[ADDR_W-1:0];
  assign l0_wr     = wr && !reset;
  assign l0_in     = l0_wr ? wr_data : '0;

endmodule

// File: tb/tb_l0_loader.sv
// Self-checking bench for l0_loader: a behavioural SRAM, directed scenarios and
// randomized backpressure, checked by a transfer-level scoreboard (expected
// address/data sequence, no write or read while L0 is full, exact latency when
// L0 never stalls).
module tb_l0_loader;

  localparam int unsigned ROW    = 8;
  localparam int unsigned BW     = 4;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned WORD_W = ROW * BW;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   num_vec;
  logic              busy, done, sram_cen, sram_wen, l0_wr;
  logic [ADDR_W-1:0] sram_addr;
  logic [WORD_W-1:0] sram_q;
  logic [ROW-1:0]    l0_full;
  logic [WORD_W-1:0] l0_in;

  logic [WORD_W-1:0] mem [2**ADDR_W];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  l0_loader #(.row(ROW), .bw(BW), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_vec(num_vec), .busy(busy), .done(done), .sram_cen(sram_cen),
    .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_q(sram_q),
    .l0_full(l0_full), .l0_wr(l0_wr), .l0_in(l0_in)
  );

  // Behavioural SRAM with one-cycle read latency
  always @(posedge clk) begin
    if (!sram_cen) sram_q <= mem[sram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // mode 0: L0 never full (exact latency checked); 1: random full;
  // 2: l0_full=8'h04 for cycles 3..5 (right after the 2nd issue).
  // poke: re-assert start with different operands during cycles 2..3.
  task automatic run_xfer(input logic [ADDR_W-1:0] base, input int num,
                          input int mode, input bit poke);
    int iss_cnt = 0;
    int wr_cnt  = 0;
    int cyc;
    bit seen_done = 0;
    logic [ADDR_W-1:0] ea;
    logic [ROW-1:0] f;
    int exp_done_cyc;
    exp_done_cyc = (num == 0) ? 1 : num + 2;

    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_vec = (ADDR_W+1)'(num); l0_full = '0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    for (cyc = 1; cyc < 400 && !seen_done; cyc++) begin
      f = '0;
      if (mode == 1 && $urandom_range(0, 2) == 0) f[$urandom_range(0, ROW-1)] = 1'b1;
      if (mode == 2 && cyc >= 3 && cyc <= 5) f = 8'h04;
      l0_full = f;
      if (poke) begin
        start     = (cyc == 2 || cyc == 3);
        base_addr = 11'h300;
        num_vec   = 12'd7;
      end
      @(negedge clk);
      if (!sram_cen) begin
        ea = base + ADDR_W'(iss_cnt);
        check("rd_addr", 32'(sram_addr), 32'(ea));
        check("rd_while_full", 32'(|f), 32'd0);
        if (mode == 0) check("rd_cycle", cyc, iss_cnt + 1);
        iss_cnt++;
      end
      if (l0_wr) begin
        ea = base + ADDR_W'(wr_cnt);
        check("wr_data", l0_in, mem[ea]);
        check("wr_while_full", 32'(|f), 32'd0);
        if (mode == 0) check("wr_cycle", cyc, wr_cnt + 2);
        wr_cnt++;
      end else begin
        check("l0_in_idle", l0_in, 32'd0);
      end
      check("wen", 32'(sram_wen), 32'd1);
      if (done) begin
        seen_done = 1;
        check("done_busy", 32'(busy), 32'd0);
        check("n_reads", iss_cnt, num);
        check("n_writes", wr_cnt, num);
        if (mode == 0) check("done_cycle", cyc, exp_done_cyc);
      end else begin
        check("run_busy", 32'(busy), 32'(num != 0));
      end
      @(posedge clk); #1;
    end
    if (!seen_done) check("timeout_done", 32'd0, 32'd1);
    start = 1'b0; l0_full = '0;
    @(negedge clk);
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_cen", 32'(sram_cen), 32'd1);
  endtask

  initial begin
    int wr_seen;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = $urandom;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_vec = '0; l0_full = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cen",  32'(sram_cen), 32'd1);
    check("rst_wen",  32'(sram_wen), 32'd1);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_wr",   32'(l0_wr), 32'd0);
    check("rst_l0in", l0_in, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Reset in the middle of a 10-word transfer after 3 words
    start = 1'b1; base_addr = 11'h123; num_vec = 12'd10;
    @(posedge clk); #1 start = 1'b0;
    wr_seen = 0;
    for (int c = 0; c < 50 && wr_seen < 3; c++) begin
      @(negedge clk);
      if (l0_wr) wr_seen++;
      @(posedge clk); #1;
    end
    check("mid_wr_count", wr_seen, 3);
    reset = 1'b1;
    @(negedge clk);
    check("rst_cyc_cen", 32'(sram_cen), 32'd1);
    check("rst_cyc_wr",  32'(l0_wr), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cen",  32'(sram_cen), 32'd1);
    check("abort_wr",   32'(l0_wr), 32'd0);
    @(negedge clk);
    check("abort_wr2",  32'(l0_wr), 32'd0);
    run_xfer(11'h123, 10, 0, 0);

    run_xfer(11'h010, 4, 0, 0);   // back-to-back, exact latency
    run_xfer(11'h000, 6, 2, 0);   // stall after 2nd issue
    run_xfer(11'h7FE, 4, 0, 0);   // address wrap
    run_xfer(11'h055, 0, 0, 0);   // empty transfer
    run_xfer(11'h040, 8, 0, 1);   // start ignored while busy
    for (int t = 0; t < 8; t++)
      run_xfer(ADDR_W'($urandom), $urandom_range(1, 40), 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
